// File: rtl/regfile_dump_reader.sv
`timescale 1ns/1ps
// regfile_dump_reader: walks a contiguous register range through a spare
// combinational read port and streams (addr, data) pairs over valid/ready.
// Each word is a snapshot taken in its READ cycle, held through backpressure.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [ADDR_W-1:0] last;

  // The read port always points at the current index, so reset parks it at 0.
  assign rd_addr = cur;
  // Decoded from the state flop only; no path from any input.
  assign busy    = (state == READ) || (state == HOLD);

  // Dump sequencer: one word per READ/HOLD pair, done/error are one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur       <= '0;
      last      <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (first_reg <= last_reg) begin
              cur   <= first_reg;
              last  <= last_reg;
              state <= READ;
            end else begin
              error <= 1'b1;
            end
          end
        end
        READ: begin
          // Capture here so later register writes cannot disturb the held word.
          out_data  <= rd_data;
          out_addr  <= cur;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (cur == last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // cur < last here, so the increment cannot wrap.
              cur   <= cur + 1'b1;
              state <= READ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
`timescale 1ns/1ps
// Bench for regfile_dump_reader: register file modelled as an array, expected
// word stream derived from the range and a snapshot of the array at start.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  first_reg, last_reg, rd_addr, out_addr;
  logic [31:0] rd_data, out_data;
  logic        out_valid, out_ready, busy, done, error;

  logic [31:0] rf [32];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done), .error(error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_addr"},   64'(rd_addr),   64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_addr"},  64'(out_addr),  64'(0));
    chk({tag, "_out_data"},  64'(out_data),  64'(0));
    chk({tag, "_busy"},      64'(busy),      64'(0));
    chk({tag, "_done"},      64'(done),      64'(0));
    chk({tag, "_error"},     64'(error),     64'(0));
  endtask

  // Reference: words appear 2 cycles after start or after the previous
  // handshake, stay until accepted, done follows the last handshake by 1 cycle.
  task automatic run_dump(input int f, input int l, input int pct, input int poke, input int max_cyc);
    logic [31:0] exp_d[$];
    logic [4:0]  exp_a[$];
    int c0, nxt, done_at;
    bit fin, ev;
    for (int i = f; i <= l; i++) begin
      exp_a.push_back(5'(i));
      exp_d.push_back(rf[i]);
    end
    start = 1'b1; first_reg = 5'(f); last_reg = 5'(l);
    out_ready = ($urandom_range(99) < pct);
    c0 = cyc; nxt = c0 + 2; done_at = -1; fin = 1'b0;
    while (!fin && cyc <= c0 + max_cyc) begin
      @(negedge clk);
      ev = (exp_d.size() > 0) && (cyc >= nxt);
      chk("dump_valid", 64'(out_valid), 64'(ev));
      chk("dump_busy",  64'(busy),  64'((exp_d.size() > 0) && (cyc > c0)));
      chk("dump_done",  64'(done),  64'(cyc == done_at));
      chk("dump_error", 64'(error), 64'(0));
      if (ev) begin
        chk("dump_addr", 64'(out_addr), 64'(exp_a[0]));
        chk("dump_data", 64'(out_data), 64'(exp_d[0]));
        if (out_ready) begin
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
          nxt = cyc + 2;
          if (exp_d.size() == 0) done_at = cyc + 1;
        end
      end
      if (cyc == done_at) fin = 1'b1;
      tick();
      start = (poke >= 0) && (cyc == c0 + poke);
      first_reg = 5'd20; last_reg = 5'd25;
      out_ready = ($urandom_range(99) < pct);
    end
    chk("dump_completed", 64'(fin), 64'(1));
    start = 1'b0;
    @(negedge clk);
    chk("post_done", 64'(done), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    chk("post_valid", 64'(out_valid), 64'(0));
    tick();
  endtask

  initial begin
    int f, l;
    rst_n = 1'b0; start = 1'b0; first_reg = '0; last_reg = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;

    // Reset state
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Full dump 0..31, always ready: word k at c+2+2k, done at c+65
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    run_dump(0, 31, 100, -1, 80);

    // Single register
    rf[5] = 32'hDEAD_BEEF;
    run_dump(5, 5, 100, -1, 10);

    // Backpressure plus snapshot on 3..4
    rf[3] = 32'hA5A5_0003; rf[4] = 32'h5A5A_0004;
    out_ready = 1'b0;
    start = 1'b1; first_reg = 5'd3; last_reg = 5'd4;
    tick(); start = 1'b0;
    @(negedge clk);
    chk("bp_read_busy", 64'(busy), 64'(1));
    chk("bp_read_valid", 64'(out_valid), 64'(0));
    tick();
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      chk("bp_hold_addr",  64'(out_addr),  64'(3));
      chk("bp_hold_data",  64'(out_data),  64'(32'hA5A5_0003));
      if (j == 0) rf[3] = 32'h0;
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_data", 64'(out_data), 64'(32'hA5A5_0003));
    tick(); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_gap_valid", 64'(out_valid), 64'(0));
    tick();
    @(negedge clk);
    chk("bp_w4_valid", 64'(out_valid), 64'(1));
    chk("bp_w4_addr",  64'(out_addr),  64'(4));
    chk("bp_w4_data",  64'(out_data),  64'(32'h5A5A_0004));
    tick(); out_ready = 1'b1;
    @(negedge clk);
    chk("bp_w4_still", 64'(out_valid), 64'(1));
    tick(); out_ready = 1'b0;
    @(negedge clk);
    chk("bp_done", 64'(done), 64'(1));
    chk("bp_done_busy", 64'(busy), 64'(0));
    tick();
    @(negedge clk);
    chk("bp_done_once", 64'(done), 64'(0));
    tick();

    // Bad range: error in c+1 only
    start = 1'b1; first_reg = 5'd10; last_reg = 5'd3;
    @(negedge clk);
    chk("bad_err_c", 64'(error), 64'(0));
    tick(); start = 1'b0;
    @(negedge clk);
    chk("bad_err_c1", 64'(error), 64'(1));
    chk("bad_valid", 64'(out_valid), 64'(0));
    chk("bad_busy", 64'(busy), 64'(0));
    chk("bad_done", 64'(done), 64'(0));
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      chk("bad_after_err", 64'(error), 64'(0));
      chk("bad_after_valid", 64'(out_valid), 64'(0));
      chk("bad_after_busy", 64'(busy), 64'(0));
    end
    tick();

    // Ignored start during a 0..7 dump
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    run_dump(0, 7, 100, 3, 30);
    run_dump(0, 7, 60, 6, 200);

    // Reset mid-dump during HOLD of word 4
    out_ready = 1'b1;
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
    tick(); start = 1'b0;
    repeat (9) tick();
    #1;
    chk("rst_pre_valid", 64'(out_valid), 64'(1));
    chk("rst_pre_addr",  64'(out_addr),  64'(4));
    rst_n = 1'b0;
    #1;
    chk_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", 64'(done), 64'(0));
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_after_done", 64'(done), 64'(0));
      chk("rst_after_busy", 64'(busy), 64'(0));
      chk("rst_after_valid", 64'(out_valid), 64'(0));
    end
    tick();
    run_dump(0, 1, 100, -1, 10);

    // Randomized ranges and backpressure
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      f = $urandom_range(31);
      l = $urandom_range(31, f);
      run_dump(f, l, $urandom_range(100, 30), -1, 2000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug read-out engine for the 32 x 32-bit register file. On a start request it walks a contiguous register range through a spare combinational read port of the register file. It streams each captured (address, data) pair out over a valid/ready interface, then pulses done. It sits beside the register file, owns the read address of that port, and never writes the register file.

## Interface

**Parameters**
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: clock, rising-edge.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Start request:
  - `start`, in, 1: start request; sampled only in IDLE.
  - `first_reg`, in, ADDR_W: first register of the range; sampled with `start`.
  - `last_reg`, in, ADDR_W: last register of the range, inclusive; sampled with `start`.
- Register file read port:
  - `rd_addr`, out, ADDR_W: drives the register file read address.
  - `rd_data`, in, DATA_W: register file read data, combinational from `rd_addr`, valid in the same cycle.
- Output stream:
  - `out_valid`, out, 1: output word valid.
  - `out_ready`, in, 1: consumer ready.
  - `out_addr`, out, ADDR_W: register index of the current word.
  - `out_data`, out, DATA_W: captured register value.
- Status:
  - `busy`, out, 1: high while a dump is in progress.
  - `done`, out, 1: one-cycle pulse after the last word is accepted.
  - `error`, out, 1: one-cycle pulse when a start is rejected because `first_reg > last_reg`.

## Operation

**States:** IDLE, READ, HOLD, DONE. The state register, current index `cur`, `out_addr`, `out_data`, `out_valid`, `done` and `error` are all flops.

**IDLE**
- `start`=1 with `first_reg <= last_reg`: latch `cur <= first_reg` and `last <= last_reg`, then go to READ.
- `start`=1 with `first_reg > last_reg`: pulse `error` for 1 cycle and stay in IDLE.

**READ**
- `rd_addr = cur`.
- At the clock edge, capture `out_data <= rd_data` and `out_addr <= cur`, set `out_valid <= 1`, and go to HOLD.

**HOLD**
- `out_valid` = 1; `out_data` and `out_addr` are held stable.
- On handshake (`out_valid && out_ready`), clear `out_valid`:
  - If `cur == last`, go to DONE.
  - Otherwise, `cur <= cur + 1` and go to READ.
- Without handshake, stay in HOLD.

**DONE**
- `done` = 1 for exactly this cycle, then go to IDLE.

**General rules**
- `rd_addr` equals `cur` in every state.
- `busy` = 1 in READ and HOLD only; `busy` = 0 in IDLE and DONE.
- `start` is ignored in READ, HOLD and DONE; no queuing.
- Snapshot semantics: each word is the register value present during its READ cycle. Register file writes during HOLD do not alter the held `out_data`.
- Index arithmetic is ADDR_W-bit unsigned. `cur` never wraps because `cur <= last` is guaranteed.
- `last_reg = 31` is legal. The range 0..31 produces 32 words.

## Timing

**Reset values:** `rd_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `busy`=0, `done`=0, `error`=0, state=IDLE, `cur`=0.

**Latency and throughput**
- `start` sampled at the end of cycle c: READ in c+1, first `out_valid` in c+2.
- With `out_ready` held at 1, word k (0-based) is valid in cycle c+2+2k.
- `done` fires in the cycle after the last handshake.
- Peak throughput: 1 word per 2 cycles.

**Error timing:** a rejected `start` in cycle c gives `error`=1 in cycle c+1 only. `out_valid` never rises.

**Handshake rules**
- `out_valid` never drops without a handshake.
- `out_data` and `out_addr` do not change while `out_valid`=1 and `out_ready`=0.
- `out_valid` does not depend combinationally on `out_ready`.

**Reset mid-dump:** asserting `rst_n`=0 in any state forces all outputs to their reset values immediately, without waiting for a clock. After reset, no `done` is issued for the aborted dump.

## Test plan

- **Full dump:** preload reg i = 0x1000_0000+i, `out_ready`=1, start with 0..31 in cycle c.
  - Expect 32 words with `out_addr` 0..31 and `out_data` 0x1000_0000..0x1000_001F.
  - Word k is valid at cycle c+2+2k.
  - `done` fires exactly once, at c+65; `busy` is high over c+1..c+64.
- **Single register:** start with `first_reg` = `last_reg` = 5, reg5 = 0xDEADBEEF.
  - Expect one word (5, 0xDEADBEEF) at c+2 and `done` at c+3.
- **Backpressure plus snapshot:** dump 3..4 with `out_ready`=0 for 5 cycles during word 3. Write reg3 = 0x0 during HOLD.
  - `out_valid` stays high and `out_data` holds the pre-write value.
  - Word 4 follows 2 cycles after the word-3 handshake.
- **Bad range and ignored start:**
  - Start with first=10, last=3: `error` pulses in c+1 only, with no `out_valid`, `done` or `busy`.
  - A second `start` pulsed during an active 0..7 dump is ignored: exactly 8 words, then one `done`.
- **Reset mid-dump:** start 0..31 and drop `rst_n` during HOLD of word 4.
  - All outputs go to 0 asynchronously and no `done` is issued.
  - After release, a new start 0..1 dumps correctly from reg 0.
